// File: rtl/tusca_escalonador_nivel.sv
// ---------------------------------------------------------------------------
// tusca_escalonador_nivel
//
// Turns each finished DHT11 measurement into a climate actuation level
// (0..4) and a humidifier relay command. Threshold shadows are loaded from the
// config manager, validated and then used for every evaluation. A level
// increase is applied at once. A level decrease needs both the hysteresis
// margin and a minimum dwell time at the current level.
//
// Optional feature: define TUSCA_ESCALONADOR_TIMEOUT_EN to enable the
// measurement timeout. If no measurement arrives for TIMEOUT_MEDIDA cycles in
// ESPERA, the FSM enters FALHA and forces full ventilation with the relay off.
//
// Ports
//   clock             system clock
//   reset             asynchronous active-low reset
//   medida_valida     1-cycle pulse, temperatura/umidade valid
//   temperatura       measured temperature (sensor units)
//   umidade           measured humidity (sensor units)
//   config_valida     1-cycle pulse, lim_* valid
//   lim_temp1..4      temperature thresholds (must be strictly increasing)
//   lim_umidade       relay-on humidity threshold
//   medida_ack        1-cycle pulse, measurement consumed
//   nivel_temperatura actuation level 0..4 (4 = maximum ventilation)
//   rele              humidifier relay
//   erro_config       1-cycle pulse, configuration rejected
//   erro_timeout      high while in FALHA
//   db_estado         FSM state code
// ---------------------------------------------------------------------------
module tusca_escalonador_nivel #(
   parameter int unsigned TEMPO_MIN_NIVEL = 500_000_000,
   parameter logic [15:0] HISTERESE       = 16'd2,
   parameter int unsigned TIMEOUT_MEDIDA  = 150_000_000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        medida_valida,
   input  logic [15:0] temperatura,
   input  logic [15:0] umidade,
   input  logic        config_valida,
   input  logic [15:0] lim_temp1,
   input  logic [15:0] lim_temp2,
   input  logic [15:0] lim_temp3,
   input  logic [15:0] lim_temp4,
   input  logic [15:0] lim_umidade,
   output logic        medida_ack,
   output logic [2:0]  nivel_temperatura,
   output logic        rele,
   output logic        erro_config,
   output logic        erro_timeout,
   output logic [2:0]  db_estado
);

   localparam int unsigned DW = $clog2(TEMPO_MIN_NIVEL + 1);
   localparam logic [DW-1:0] TEMPO_MAX = DW'(TEMPO_MIN_NIVEL);
   localparam logic [DW-1:0] TEMPO_UM  = DW'(1);

   typedef enum logic [2:0] {
      ESPERA  = 3'd0,
      CAPTURA = 3'd1,
      AVALIA  = 3'd2,
      APLICA  = 3'd3,
      FALHA   = 3'd4
   } estado_t;

   estado_t           estado;
   logic [DW-1:0]     tempo_nivel;
   logic [3:0][15:0]  lim_sh;
   logic [15:0]       lim_um_sh;
   logic              pendente;

   // Data-only registers: no reset, they are always written before being used.
   logic [15:0]       temp_cap;
   logic [15:0]       umid_cap;
   logic [2:0]        alvo_reg;
   logic [3:0][15:0]  pend_lim;
   logic [15:0]       pend_um;

   logic              captura;
   logic [3:0][15:0]  cfg_lim;
   logic [15:0]       cfg_um;
   logic              cfg_ok;
   logic [2:0]        sobe;
   logic [2:0]        desce;
   logic [2:0]        alvo;
   logic              rele_liga;
   logic              rele_desliga;

   // Number of thresholds reached by a value; 17-bit so value+margin never wraps.
   function automatic logic [2:0] conta_limites(input logic [16:0] valor,
                                                input logic [3:0][15:0] lim);
      logic [2:0] n;
      n = 3'd0;
      for (int k = 0; k < 4; k++) begin
         if (valor >= {1'b0, lim[k]}) n = n + 3'd1;
      end
      return n;
   endfunction

   function automatic logic valida_limites(input logic [3:0][15:0] lim);
      return (lim[0] < lim[1]) && (lim[1] < lim[2]) && (lim[2] < lim[3]);
   endfunction

   function automatic logic [DW-1:0] incr_sat(input logic [DW-1:0] v);
      return (v == TEMPO_MAX) ? v : v + TEMPO_UM;
   endfunction

   assign captura = medida_valida && (estado == ESPERA || estado == FALHA);

   // A fresh config pulse wins over an older pending one.
   always_comb begin
      cfg_lim = {lim_temp4, lim_temp3, lim_temp2, lim_temp1};
      cfg_um  = lim_umidade;
      if (pendente && !config_valida) begin
         cfg_lim = pend_lim;
         cfg_um  = pend_um;
      end
      cfg_ok = valida_limites(cfg_lim);
   end

   // Rising uses the raw count; falling is only allowed below the margin.
   always_comb begin
      sobe  = conta_limites({1'b0, temp_cap}, lim_sh);
      desce = conta_limites({1'b0, temp_cap} + {1'b0, HISTERESE}, lim_sh);
      alvo  = (sobe >= nivel_temperatura) ? sobe : desce;
      rele_liga    = (umid_cap < lim_um_sh);
      rele_desliga = ({1'b0, umid_cap} >= ({1'b0, lim_um_sh} + {1'b0, HISTERESE}));
   end

   always_ff @(posedge clock) begin
      if (captura) begin
         temp_cap <= temperatura;
         umid_cap <= umidade;
      end
      if (estado == AVALIA) alvo_reg <= alvo;
      if (config_valida && estado != ESPERA && estado != FALHA) begin
         pend_lim <= {lim_temp4, lim_temp3, lim_temp2, lim_temp1};
         pend_um  <= lim_umidade;
      end
   end

`ifdef TUSCA_ESCALONADOR_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_MEDIDA + 1);
   localparam logic [TW-1:0] TIMEOUT_FIM = TW'(TIMEOUT_MEDIDA - 1);
   localparam logic [TW-1:0] TIMEOUT_UM  = TW'(1);
   logic [TW-1:0] cnt_timeout;
`else
   assign erro_timeout = 1'b0;
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado            <= ESPERA;
         tempo_nivel       <= TEMPO_MAX;
         lim_sh            <= {4{16'hFFFF}};
         lim_um_sh         <= 16'd0;
         pendente          <= 1'b0;
         medida_ack        <= 1'b0;
         nivel_temperatura <= 3'd0;
         rele              <= 1'b0;
         erro_config       <= 1'b0;
`ifdef TUSCA_ESCALONADOR_TIMEOUT_EN
         erro_timeout      <= 1'b0;
         cnt_timeout       <= '0;
`endif
      end else begin
         medida_ack  <= 1'b0;
         erro_config <= 1'b0;
         tempo_nivel <= incr_sat(tempo_nivel);

         // Config is checked only while idle; otherwise it waits for ESPERA.
         if (estado == ESPERA || estado == FALHA) begin
            if (config_valida || pendente) begin
               pendente <= 1'b0;
               if (cfg_ok) begin
                  lim_sh    <= cfg_lim;
                  lim_um_sh <= cfg_um;
               end else begin
                  erro_config <= 1'b1;
               end
            end
         end else if (config_valida) begin
            pendente <= 1'b1;
         end

         case (estado)
            ESPERA: begin
               if (captura) begin
                  medida_ack <= 1'b1;
                  estado     <= CAPTURA;
`ifdef TUSCA_ESCALONADOR_TIMEOUT_EN
                  cnt_timeout <= '0;
               end else if (cnt_timeout == TIMEOUT_FIM) begin
                  cnt_timeout       <= '0;
                  estado            <= FALHA;
                  nivel_temperatura <= 3'd4;
                  rele              <= 1'b0;
                  erro_timeout      <= 1'b1;
                  tempo_nivel       <= TEMPO_MAX;
               end else begin
                  cnt_timeout <= cnt_timeout + TIMEOUT_UM;
`endif
               end
            end
            // ---- capture -> evaluate
            CAPTURA: estado <= AVALIA;
            // ---- evaluate -> apply
            AVALIA:  estado <= APLICA;
            // ---- apply -> idle
            APLICA: begin
               if ((alvo_reg > nivel_temperatura) ||
                   ((alvo_reg < nivel_temperatura) && (tempo_nivel == TEMPO_MAX))) begin
                  nivel_temperatura <= alvo_reg;
                  tempo_nivel       <= '0;
               end
               if (rele_liga) begin
                  rele <= 1'b1;
               end else if (rele_desliga) begin
                  rele <= 1'b0;
               end
               estado <= ESPERA;
            end
            FALHA: begin
`ifdef TUSCA_ESCALONADOR_TIMEOUT_EN
               // Dwell stays saturated so the first evaluation may lower the level.
               tempo_nivel <= TEMPO_MAX;
               if (captura) begin
                  medida_ack   <= 1'b1;
                  erro_timeout <= 1'b0;
                  estado       <= CAPTURA;
               end
`else
               estado <= ESPERA;
`endif
            end
            default: estado <= ESPERA;
         endcase
      end
   end

   assign db_estado = estado;

endmodule

// File: tb/tb_tusca_escalonador_nivel.sv
// ---------------------------------------------------------------------------
// Testbench for tusca_escalonador_nivel (TEMPO_MIN_NIVEL=10, HISTERESE=2,
// TIMEOUT_MEDIDA=50). Define TUSCA_ESCALONADOR_TIMEOUT_EN for both files to
// include the timeout sequence.
// ---------------------------------------------------------------------------
module tb_tusca_escalonador_nivel;

   localparam int T  = 10;
   localparam int H  = 2;
   localparam int TO = 50;

   logic        clock = 1'b0;
   logic        reset;
   logic        medida_valida;
   logic [15:0] temperatura;
   logic [15:0] umidade;
   logic        config_valida;
   logic [15:0] lim_temp1, lim_temp2, lim_temp3, lim_temp4, lim_umidade;
   logic        medida_ack;
   logic [2:0]  nivel_temperatura;
   logic        rele;
   logic        erro_config;
   logic        erro_timeout;
   logic [2:0]  db_estado;

   tusca_escalonador_nivel #(
      .TEMPO_MIN_NIVEL(T),
      .HISTERESE      (16'd2),
      .TIMEOUT_MEDIDA (TO)
   ) dut (
      .clock            (clock),
      .reset            (reset),
      .medida_valida    (medida_valida),
      .temperatura      (temperatura),
      .umidade          (umidade),
      .config_valida    (config_valida),
      .lim_temp1        (lim_temp1),
      .lim_temp2        (lim_temp2),
      .lim_temp3        (lim_temp3),
      .lim_temp4        (lim_temp4),
      .lim_umidade      (lim_umidade),
      .medida_ack       (medida_ack),
      .nivel_temperatura(nivel_temperatura),
      .rele             (rele),
      .erro_config      (erro_config),
      .erro_timeout     (erro_timeout),
      .db_estado        (db_estado)
   );

   always #5 clock = ~clock;

   // Posedge count; read only at negedges.
   int ciclo = 0;
   always @(posedge clock) ciclo <= ciclo + 1;

   int n_vet  = 0;
   int n_erro = 0;

   // Reference model state
   int m_lim[4];
   int m_lu;
   int m_nivel;
   int m_rele;
   int m_echg;   // edge of last level change

   typedef struct {
      logic [15:0] temp;
      logic [15:0] umid;
      int          ocioso;
      int          exp_n;
      int          exp_r;
   } vetor_t;
   vetor_t tab[9];

   task automatic verifica(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
      n_vet++;
      if (atual !== esperado) begin
         n_erro++;
         $display("FAIL %s: got %0d, expected %0d", nome, atual, esperado);
      end
   endtask

   function automatic int conta(input int v);
      int n;
      n = 0;
      for (int k = 0; k < 4; k++) if (v >= m_lim[k]) n++;
      return n;
   endfunction

   function automatic bit cfg_ok();
      return (lim_temp1 < lim_temp2) && (lim_temp2 < lim_temp3) && (lim_temp3 < lim_temp4);
   endfunction

   task automatic carrega();
      m_lim[0] = int'(lim_temp1);
      m_lim[1] = int'(lim_temp2);
      m_lim[2] = int'(lim_temp3);
      m_lim[3] = int'(lim_temp4);
      m_lu     = int'(lim_umidade);
   endtask

   task automatic modelo_reset();
      for (int k = 0; k < 4; k++) m_lim[k] = 65535;
      m_lu    = 0;
      m_nivel = 0;
      m_rele  = 0;
      m_echg  = -1000000;
   endtask

   task automatic modelo_aplica(input int t, input int u, input int e);
      int sobe, alvo, perm;
      sobe = conta(t);
      alvo = (sobe >= m_nivel) ? sobe : conta(t + H);
      perm = e - m_echg - 1;
      if (perm > T) perm = T;
      if (alvo > m_nivel || (alvo < m_nivel && perm == T)) begin
         m_nivel = alvo;
         m_echg  = e;
      end
      if (u < m_lu) m_rele = 1;
      else if (u >= m_lu + H) m_rele = 0;
   endtask

   task automatic poe_cfg(input int l1, input int l2, input int l3, input int l4, input int lu);
      lim_temp1   = 16'(l1);
      lim_temp2   = 16'(l2);
      lim_temp3   = 16'(l3);
      lim_temp4   = 16'(l4);
      lim_umidade = 16'(lu);
   endtask

   task automatic cfg_aleatoria();
      int l1, l2, l3, l4, lu;
      l1 = int'($urandom_range(5, 30));
      l2 = l1 + int'($urandom_range(1, 10));
      l3 = l2 + int'($urandom_range(1, 10));
      l4 = l3 + int'($urandom_range(1, 10));
      if ($urandom_range(0, 2) == 0) l3 = l2;
      lu = ($urandom_range(0, 4) == 0) ? 65534 : int'($urandom_range(50, 70));
      poe_cfg(l1, l2, l3, l4, lu);
   endtask

   task automatic ocioso(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic zeros(input string nome);
      verifica({nome, " nivel"}, 32'(nivel_temperatura), 0);
      verifica({nome, " rele"}, 32'(rele), 0);
      verifica({nome, " ack"}, 32'(medida_ack), 0);
      verifica({nome, " erro_config"}, 32'(erro_config), 0);
      verifica({nome, " erro_timeout"}, 32'(erro_timeout), 0);
      verifica({nome, " estado"}, 32'(db_estado), 0);
   endtask

   // Called at a negedge while ESPERA/FALHA.
   task automatic configurar(input string nome);
      bit ok;
      config_valida = 1'b1;
      @(negedge clock);
      config_valida = 1'b0;
      ok = cfg_ok();
      if (ok) carrega();
      verifica({nome, " erro_config"}, 32'(erro_config), 32'(!ok));
      @(negedge clock);
      verifica({nome, " erro_config pulso"}, 32'(erro_config), 0);
   endtask

   // modo: 0 plain, 1 config in the capture cycle, 2 config during AVALIA.
   task automatic medir(input logic [15:0] t, input logic [15:0] u, input int modo,
                        input bit usa_tab, input int tn, input int tr, input string nome);
      int  c, en, er;
      bit  ok;
      ok = 1'b0;
      temperatura   = t;
      umidade       = u;
      medida_valida = 1'b1;
      if (modo == 1) begin
         config_valida = 1'b1;
         ok = cfg_ok();
         if (ok) carrega();
      end
      c = ciclo + 1;
      @(negedge clock);
      config_valida = 1'b0;
      if (modo == 1) verifica({nome, " erro_config junto"}, 32'(erro_config), 32'(!ok));
      verifica({nome, " ack"}, 32'(medida_ack), 1);
      verifica({nome, " estado captura"}, 32'(db_estado), 1);
      temperatura   = 16'($urandom);
      umidade       = 16'($urandom);
      medida_valida = 1'($urandom_range(0, 1));
      @(negedge clock);
      verifica({nome, " ack unico"}, 32'(medida_ack), 0);
      if (modo == 2) begin
         config_valida = 1'b1;
         ok = cfg_ok();
      end
      temperatura   = 16'($urandom);
      medida_valida = 1'($urandom_range(0, 1));
      @(negedge clock);
      config_valida = 1'b0;
      verifica({nome, " ack apos"}, 32'(medida_ack), 0);
      verifica({nome, " nivel latencia"}, 32'(nivel_temperatura), 32'(m_nivel));
      verifica({nome, " estado aplica"}, 32'(db_estado), 3);
      @(negedge clock);
      medida_valida = 1'b0;
      modelo_aplica(int'(t), int'(u), c + 3);
      en = usa_tab ? tn : m_nivel;
      er = usa_tab ? tr : m_rele;
      verifica({nome, " nivel"}, 32'(nivel_temperatura), 32'(en));
      verifica({nome, " rele"}, 32'(rele), 32'(er));
      verifica({nome, " erro_timeout"}, 32'(erro_timeout), 0);
      verifica({nome, " estado espera"}, 32'(db_estado), 0);
      if (modo == 2) begin
         @(negedge clock);
         verifica({nome, " erro_config pendente"}, 32'(erro_config), 32'(!ok));
         if (ok) carrega();
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      reset         = 1'b0;
      medida_valida = 1'b0;
      config_valida = 1'b0;
      temperatura   = '0;
      umidade       = '0;
      poe_cfg(0, 0, 0, 0, 0);
      modelo_reset();
      repeat (3) @(negedge clock);
      zeros("reset");
      reset = 1'b1;
      @(negedge clock);
      zeros("pos reset");

      poe_cfg(20, 25, 30, 35, 60);
      configurar("cfg inicial");

      tab[0] = '{16'd27, 16'd65,  2, 2, 0};
      tab[1] = '{16'd24, 16'd65,  0, 2, 0};
      tab[2] = '{16'd17, 16'd65,  0, 2, 0};
      tab[3] = '{16'd17, 16'd65, 10, 0, 0};
      tab[4] = '{16'd40, 16'd55,  0, 4, 1};
      tab[5] = '{16'd40, 16'd61,  0, 4, 1};
      tab[6] = '{16'd40, 16'd62,  0, 4, 0};
      tab[7] = '{16'd34, 16'd62,  0, 4, 0};
      tab[8] = '{16'd32, 16'd59,  0, 3, 1};
      for (int i = 0; i < 9; i++) begin
         ocioso(tab[i].ocioso);
         medir(tab[i].temp, tab[i].umid, 0, 1'b1, tab[i].exp_n, tab[i].exp_r,
               $sformatf("tab%0d", i));
      end

      // Rejected config keeps the old limits
      poe_cfg(10, 12, 11, 13, 60);
      configurar("cfg invalida");
      ocioso(12);
      medir(16'd14, 16'd65, 0, 1'b1, 0, 0, "limites antigos");

      // Config arriving during AVALIA waits for ESPERA
      poe_cfg(10, 12, 13, 14, 60);
      medir(16'd27, 16'd65, 2, 1'b1, 2, 0, "cfg pendente");
      medir(16'd14, 16'd65, 0, 1'b1, 4, 0, "cfg pendente aplicada");

      // Config and measurement in the same cycle: new limits win
      ocioso(12);
      poe_cfg(30, 40, 50, 60, 60);
      medir(16'd45, 16'd65, 1, 1'b1, 2, 0, "cfg junto");

      // 17-bit margin sums must not wrap
      poe_cfg(10, 20, 30, 65535, 65535);
      configurar("cfg topo");
      medir(16'hFFFF, 16'hFFFE, 0, 1'b1, 4, 1, "topo sobe");
      ocioso(12);
      medir(16'hFFFE, 16'hFFFF, 0, 1'b1, 4, 1, "topo sem wrap");

      poe_cfg(15, 22, 30, 41, 60);
      configurar("cfg rnd base");
      for (int i = 0; i < 80; i++) begin
         int sel, modo;
         logic [15:0] t, u;
         sel  = int'($urandom_range(0, 9));
         modo = 0;
         ocioso(int'($urandom_range(0, 12)));
         if (sel >= 7) cfg_aleatoria();
         if (sel == 7) modo = 1;
         else if (sel == 8) modo = 2;
         else if (sel == 9) configurar($sformatf("rnd%0d cfg", i));
         t = 16'($urandom_range(0, 70));
         if ($urandom_range(0, 11) == 0) t = 16'hFFFF - 16'($urandom_range(0, 1));
         u = 16'($urandom_range(40, 80));
         if ($urandom_range(0, 7) == 0) u = 16'hFFFF - 16'($urandom_range(0, 2));
         medir(t, u, modo, 1'b0, 0, 0, $sformatf("rnd%0d", i));
      end

      // Asynchronous reset in the middle of an evaluation
      poe_cfg(20, 25, 30, 35, 60);
      configurar("t6 cfg");
      medir(16'd40, 16'd55, 0, 1'b1, 4, 1, "t6 pre");
      temperatura   = 16'd27;
      umidade       = 16'd65;
      medida_valida = 1'b1;
      @(negedge clock);
      medida_valida = 1'b0;
      @(negedge clock);
      verifica("t6 estado avalia", 32'(db_estado), 2);
      reset = 1'b0;
      #1;
      zeros("t6 reset assinc");
      @(negedge clock);
      reset = 1'b1;
      modelo_reset();
      @(negedge clock);
      zeros("t6 pos reset");
      medir(16'd27, 16'd65, 0, 1'b1, 0, 0, "t6 limites de reset");
      configurar("t6 cfg nova");
      medir(16'd27, 16'd65, 0, 1'b1, 2, 0, "t6 medida nova");

`ifdef TUSCA_ESCALONADOR_TIMEOUT_EN
      ocioso(TO - 1);
      verifica("t5 antes estado", 32'(db_estado), 0);
      verifica("t5 antes erro_timeout", 32'(erro_timeout), 0);
      ocioso(1);
      m_nivel = 4;
      m_rele  = 0;
      m_echg  = -1000000;
      verifica("t5 falha estado", 32'(db_estado), 4);
      verifica("t5 falha erro_timeout", 32'(erro_timeout), 1);
      verifica("t5 falha nivel", 32'(nivel_temperatura), 4);
      verifica("t5 falha rele", 32'(rele), 0);
      medir(16'd10, 16'd65, 0, 1'b1, 0, 0, "t5 saida falha");
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vet, n_erro);
      $finish;
   end

endmodule
